// File: rtl/icache_refill_ctrl.sv
// Purpose  : direct-mapped read-only instruction cache with a line-refill FSM.
// Latency  : hit returns o_data combinationally; miss costs WORDS_PER_LINE+1 cycles plus memory gap cycles.
// Backpress: o_stall holds the fetch PC during a miss; memory paces the refill with i_mem_valid (gaps allowed).
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_req, i_addr, i_flush   fetch request, byte address, invalidate-all
//   o_data, o_ready, o_stall instruction word, hit indication, hold-PC
//   o_mem_req, o_mem_addr    refill request and line base address
//   i_mem_valid, i_mem_data  refill beats, ascending word order from word 0
module icache_refill_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_flush,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_ready,
   output logic                  o_stall,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_valid,
   input  logic [DATA_WIDTH-1:0] i_mem_data
);

   localparam int WSEL_W = $clog2(WORDS_PER_LINE);
   localparam int OFF    = WSEL_W + 2;
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_WIDTH - OFF - IDX_W;

   typedef enum logic {
      S_IDLE,
      S_REFILL
   } state_t;

   state_t                state_q, state_d;
   logic [WSEL_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [NUM_LINES-1:0]  valid_q, valid_d;

   // Tag and data storage carry no reset; valid_q alone qualifies them.
   logic [TAG_W-1:0]      tag_q  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

   logic [WSEL_W-1:0] req_word;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              hit;
   logic              beat_we;
   logic              last_beat;
   logic [1:0]        unused_addr_bits;

   assign req_word         = i_addr[OFF-1:2];
   assign req_idx          = i_addr[OFF+IDX_W-1:OFF];
   assign req_tag          = i_addr[ADDR_WIDTH-1:OFF+IDX_W];
   assign fill_idx         = base_q[OFF+IDX_W-1:OFF];
   assign fill_tag         = base_q[ADDR_WIDTH-1:OFF+IDX_W];
   assign unused_addr_bits = i_addr[1:0];

   assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign beat_we   = (state_q == S_REFILL) && i_mem_valid;
   assign last_beat = beat_we && (cnt_q == WSEL_W'(WORDS_PER_LINE - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      flush_pend_d = flush_pend_q;
      valid_d      = valid_q;
      o_ready      = 1'b0;
      o_stall      = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_addr   = '0;
      o_data       = '0;

      case (state_q)
         S_IDLE: begin
            // A flush cycle never reports a hit: the line is about to vanish.
            o_ready = i_req && hit && !i_flush;
            o_stall = i_req && (!hit || i_flush);
            if (o_ready) begin
               o_data = data_q[req_idx][req_word];
            end
            if (i_flush) begin
               valid_d = '0;
            end else if (i_req && !hit) begin
               base_d  = {i_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
               cnt_d   = '0;
               state_d = S_REFILL;
            end
         end

         S_REFILL: begin
            o_mem_req  = 1'b1;
            o_mem_addr = base_q;
            o_stall    = 1'b1;
            if (i_flush) begin
               flush_pend_d = 1'b1;
            end
            if (beat_we) begin
               cnt_d = cnt_q + WSEL_W'(1);
            end
            if (last_beat) begin
               // A flush seen at any point of the refill wipes everything,
               // including the line just installed.
               if (flush_pend_q || i_flush) begin
                  valid_d = '0;
               end else begin
                  valid_d[fill_idx] = 1'b1;
               end
               flush_pend_d = 1'b0;
               cnt_d        = '0;
               state_d      = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         base_q       <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (beat_we) begin
         data_q[fill_idx][cnt_q] <= i_mem_data;
      end
      if (last_beat) begin
         tag_q[fill_idx] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Purpose  : directed self-checking bench for icache_refill_ctrl.
// Latency  : inputs driven on the falling edge, outputs sampled 1ns later.
// Backpress: memory beats supplied with and without gap cycles.
module tb_icache_refill_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        flush;
   logic [31:0] data;
   logic        ready;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;

   int n_cmp;
   int n_bad;

   icache_refill_ctrl #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .NUM_LINES     (16),
      .WORDS_PER_LINE(4)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_addr     (addr),
      .i_flush    (flush),
      .o_data     (data),
      .o_ready    (ready),
      .o_stall    (stall),
      .o_mem_req  (mem_req),
      .o_mem_addr (mem_addr),
      .i_mem_valid(mem_valid),
      .i_mem_data (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus only: miss is already presented; drives four gap-free beats
   // and reports how many of those cycles had o_mem_req high and the
   // address seen on the first one.
   task automatic run_beats(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            output int req_cycles, output logic [31:0] first_addr);
      logic [31:0] d [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      req_cycles = 0;
      first_addr = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_valid = 1'b1;
         mem_data  = d[i];
         #1;
         if (mem_req) req_cycles++;
         if (i == 0) first_addr = mem_addr;
      end
      @(negedge clk);
      mem_valid = 1'b0;
      mem_data  = '0;
   endtask

   task automatic test_reset();
      req = 0; addr = 0; flush = 0; mem_valid = 0; mem_data = 0;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: mem_req=%b stall=%b ready=%b, want 0 0 0", mem_req, stall, ready);
      end
      n_cmp++;
      if (mem_addr !== 32'h0 || data !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_buses: mem_addr=%h data=%h, want 0 0", mem_addr, data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // memory beats are ignored outside a refill
      mem_valid = 1'b1; mem_data = 32'hBAD0BAD0;
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_mem_valid: mem_req=%b, want 0", mem_req);
      end
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_1234;
      #1;
      n_cmp++;
      if (stall !== 1'b1 || ready !== 1'b0) begin
         n_bad++;
         $display("FAIL cold_any_addr: stall=%b ready=%b, want 1 0", stall, ready);
      end
      #1 req = 1'b0;
   endtask

   task automatic test_cold_miss();
      int          rc;
      logic [31:0] fa;
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_0040;
      #1;
      n_cmp++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL cold_miss_cycle0: stall=%b mem_req=%b, want 1 0", stall, mem_req);
      end
      run_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, rc, fa);
      #1;
      n_cmp++;
      if (rc !== 4 || fa !== 32'h40) begin
         n_bad++;
         $display("FAIL cold_refill_req: req_cycles=%0d addr=%h, want 4 00000040", rc, fa);
      end
      n_cmp++;
      if (ready !== 1'b1 || data !== 32'h11111111 || mem_req !== 1'b0 || stall !== 1'b0) begin
         n_bad++;
         $display("FAIL cold_first_hit: ready=%b data=%h mem_req=%b stall=%b, want 1 11111111 0 0",
                  ready, data, mem_req, stall);
      end
   endtask

   task automatic test_hit();
      logic [31:0] a [3];
      logic [31:0] e [3];
      a[0] = 32'h48; a[1] = 32'h44; a[2] = 32'h4F;
      e[0] = 32'h33333333; e[1] = 32'h22222222; e[2] = 32'h44444444;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req = 1'b1; addr = a[i];
         #1;
         n_cmp++;
         if (ready !== 1'b1 || data !== e[i] || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_%0d: ready=%b data=%h stall=%b mem_req=%b, want 1 %h 0 0",
                     i, ready, data, stall, mem_req, e[i]);
         end
      end
   endtask

   task automatic test_conflict();
      int          rc;
      logic [31:0] fa;
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_0440;
      #1;
      n_cmp++;
      if (stall !== 1'b1 || ready !== 1'b0) begin
         n_bad++;
         $display("FAIL conflict_miss: stall=%b ready=%b, want 1 0", stall, ready);
      end
      run_beats(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, rc, fa);
      #1;
      n_cmp++;
      if (rc !== 4 || fa !== 32'h440) begin
         n_bad++;
         $display("FAIL conflict_refill: req_cycles=%0d addr=%h, want 4 00000440", rc, fa);
      end
      n_cmp++;
      if (ready !== 1'b1 || data !== 32'hA0A0A0A0) begin
         n_bad++;
         $display("FAIL conflict_hit: ready=%b data=%h, want 1 a0a0a0a0", ready, data);
      end
      @(negedge clk);
      addr = 32'h0000_0040;
      #1;
      n_cmp++;
      if (stall !== 1'b1 || ready !== 1'b0) begin
         n_bad++;
         $display("FAIL evicted_miss: stall=%b ready=%b, want 1 0", stall, ready);
      end
      #1 req = 1'b0;
   endtask

   task automatic test_gaps();
      logic        v [7];
      logic [31:0] d [7];
      int          req_hi;
      logic [31:0] e [4];
      v[0]=1; v[1]=0; v[2]=0; v[3]=1; v[4]=1; v[5]=0; v[6]=1;
      d[0]=32'hB0000000; d[1]=32'hDEADBEEF; d[2]=32'hDEADBEEF; d[3]=32'hB1111111;
      d[4]=32'hB2222222; d[5]=32'hDEADBEEF; d[6]=32'hB3333333;
      e[0]=32'hB0000000; e[1]=32'hB1111111; e[2]=32'hB2222222; e[3]=32'hB3333333;
      req_hi = 0;
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_0080;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         // request changes during refill must be ignored
         addr = 32'h0000_0900 + 32'(i * 4);
         mem_valid = v[i]; mem_data = d[i];
         #1;
         if (mem_req === 1'b1 && mem_addr === 32'h80) req_hi++;
      end
      @(negedge clk);
      mem_valid = 1'b0; addr = 32'h0000_0080;
      #1;
      n_cmp++;
      if (req_hi !== 7 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL gap_refill_span: cycles=%0d mem_req_after=%b, want 7 0", req_hi, mem_req);
      end
      for (int w = 0; w < 4; w++) begin
         if (w != 0) begin
            @(negedge clk);
            addr = 32'h80 + 32'(w * 4);
         end
         #1;
         n_cmp++;
         if (ready !== 1'b1 || data !== e[w]) begin
            n_bad++;
            $display("FAIL gap_word_%0d: ready=%b data=%h, want 1 %h", w, ready, data, e[w]);
         end
      end
   endtask

   task automatic test_flush();
      int          rc;
      logic [31:0] fa;
      // flush while idle: no hit reported, no refill, everything invalidated
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_0080; flush = 1'b1;
      #1;
      n_cmp++;
      if (ready !== 1'b0 || stall !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_flush_cycle: ready=%b stall=%b, want 0 1", ready, stall);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_cmp++;
      if (stall !== 1'b1 || ready !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_flush_after: stall=%b ready=%b mem_req=%b, want 1 0 0", stall, ready, mem_req);
      end
      #1 req = 1'b0;
      // flush during a refill: refill completes, line stays invalid
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_00C0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_valid = 1'b1; mem_data = 32'hC0C0C000 + 32'(i);
         flush = (i == 1);
      end
      @(negedge clk);
      mem_valid = 1'b0; flush = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || ready !== 1'b0 || stall !== 1'b1) begin
         n_bad++;
         $display("FAIL refill_flush: mem_req=%b ready=%b stall=%b, want 0 0 1", mem_req, ready, stall);
      end
      #1 req = 1'b0;
      // the same line refills cleanly and is usable afterwards
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_00C4;
      run_beats(32'hD0, 32'hD1, 32'hD2, 32'hD3, rc, fa);
      #1;
      n_cmp++;
      if (ready !== 1'b1 || data !== 32'hD1 || fa !== 32'hC0) begin
         n_bad++;
         $display("FAIL refill_after_flush: ready=%b data=%h addr=%h, want 1 000000d1 000000c0", ready, data, fa);
      end
   endtask

   task automatic test_reset_mid_refill();
      int          rc;
      logic [31:0] fa;
      @(negedge clk);
      req = 1'b1; addr = 32'h0000_0040;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_valid = 1'b1; mem_data = 32'hEE000000 + 32'(i);
      end
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_refill_active: mem_req=%b, want 1", mem_req);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_abort: mem_req=%b mem_addr=%h, want 0 0", mem_req, mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (stall !== 1'b1 || ready !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_miss: stall=%b ready=%b, want 1 0", stall, ready);
      end
      run_beats(32'hF0, 32'hF1, 32'hF2, 32'hF3, rc, fa);
      addr = 32'h0000_004C;
      #1;
      n_cmp++;
      if (rc !== 4 || ready !== 1'b1 || data !== 32'hF3) begin
         n_bad++;
         $display("FAIL post_reset_refill: req_cycles=%0d ready=%b data=%h, want 4 1 000000f3", rc, ready, data);
      end
      #1 req = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_gaps();
      test_flush();
      test_reset_mid_refill();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
